ram_arbiter: RTL and testbench

//  Sole owner of the byte-wide CPU RAM port; sits downstream of the IF and MEM stages.

---
 rtl/ram_arbiter_if.sv | 47 ++++
 rtl/ram_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundles every signal of the RAM arbiter apart from clk/rst.
//   The arbiter uses the master modport. It drives the RAM bus, the done
//   pulses, the read data and busy_o.
//   The slave modport is the environment side: the IF/MEM requesters and
//   the RAM itself.
//   rdy_i                          grant enable
//   if_req_i/if_addr_i             IF word fetch request
//   if_data_o/if_done_o            IF result and completion pulse
//   mem_req_i/we/len/addr/wdata    MEM load/store request
//   mem_rdata_o/mem_done_o         MEM load result and completion pulse
//   ram_a_o/ram_wr_o/ram_dout_o    byte-wide RAM command
//   ram_din_i                      RAM read byte (1-cycle latency)
//   busy_o                         transfer in progress
interface ram_arbiter_if;
    logic        rdy_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
    logic        busy_o;

    modport master (
        input  rdy_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i,
               mem_addr_i, mem_wdata_i, ram_din_i,
        output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_a_o,
               ram_wr_o, ram_dout_o, busy_o
    );

    modport slave (
        output rdy_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i,
               mem_addr_i, mem_wdata_i, ram_din_i,
        input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_a_o,
               ram_wr_o, ram_dout_o, busy_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Owns the byte-wide CPU RAM port. Arbitrates between IF word fetches and
//   MEM loads/stores, with MEM having priority. Each request is split into
//   single-byte RAM accesses in little-endian order. Read bytes are
//   assembled into a 32-bit word, and completion is signalled with a
//   one-cycle done pulse. Every output is registered.
//   clk  clock
//   rst  asynchronous active-high reset; it aborts any transfer without
//        issuing a done pulse
//   bus  ram_arbiter_if.master; all request, response and RAM signals
module ram_arbiter (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic        own_mem_q, own_mem_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  n_q, n_d;           // transfer length in bytes: 1, 2 or 4
    logic [2:0]  k_q, k_d;           // index of the byte currently on the RAM bus
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] acc_q, acc_d;       // read bytes assembled so far
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic        ram_wr_q, ram_wr_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        busy_q, busy_d;
    logic [31:0] word_v;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            own_mem_q   <= 1'b0;
            addr_q      <= '0;
            n_q         <= '0;
            k_q         <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_mem_q   <= own_mem_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            k_q         <= k_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            busy_q      <= busy_d;
        end
    end

    // The next value of every register, registered outputs included, is
    // computed here, so each output is valid in the same cycle as the state
    // it belongs to.
    always_comb begin
        state_d     = state_q;
        own_mem_d   = own_mem_q;
        addr_d      = addr_q;
        n_d         = n_q;
        k_d         = k_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_a_d     = '0;
        ram_wr_d    = 1'b0;
        ram_dout_d  = '0;
        word_v      = acc_q;

        case (state_q)
            IDLE: begin
                if (bus.rdy_i && (bus.mem_req_i || bus.if_req_i)) begin
                    own_mem_d = bus.mem_req_i;
                    k_d       = '0;
                    acc_d     = '0;
                    if (bus.mem_req_i) begin
                        addr_d  = bus.mem_addr_i;
                        n_d     = len_to_n(bus.mem_len_i);
                        wdata_d = bus.mem_wdata_i;
                    end else begin
                        addr_d  = bus.if_addr_i;
                        n_d     = 3'd4;
                        wdata_d = '0;
                    end
                    // Byte 0 goes out together with the state change.
                    ram_a_d = addr_d;
                    if (bus.mem_req_i && bus.mem_we_i) begin
                        state_d    = WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = wdata_d[7:0];
                    end else begin
                        state_d = RD;
                    end
                end
            end

            WR: begin
                if (k_q == n_q - 3'd1) begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end else begin
                    k_d        = k_q + 3'd1;
                    ram_a_d    = addr_q + 32'(k_d);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = get_byte(wdata_q, k_d[1:0]);
                end
            end

            RD: begin
                // ram_din_i carries the byte for the address presented in
                // the previous cycle, which is index k_q-1.
                if (k_q != 3'd0) begin
                    word_v = put_byte(acc_q, 2'(k_q - 3'd1), bus.ram_din_i);
                    acc_d  = word_v;
                end
                if (k_q == n_q) begin
                    state_d = DONE;
                    if (own_mem_q) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = word_v;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = word_v;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                    if (k_d < n_q) begin
                        ram_a_d = addr_q + 32'(k_d);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.if_data_o   = if_data_q;
    assign bus.if_done_o   = if_done_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.mem_done_o  = mem_done_q;
    assign bus.ram_a_o     = ram_a_q;
    assign bus.ram_wr_o    = ram_wr_q;
    assign bus.ram_dout_o  = ram_dout_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter. A byte RAM model with one-cycle read
//   latency sits on the RAM port. Table-driven single transfers come first,
//   followed by hand-written sequences for priority, reset abort and rdy_i
//   gating.
module tb_ram_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ram_arbiter_if bif ();

    ram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: a preloaded image, overlaid with bytes written by the DUT
    // (indexed by the low 12 address bits).
    bit [7:0] wram [4096];
    bit       wv   [4096];

    function automatic logic [7:0] init_val(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h11;
            32'h0000_0101: return 8'h22;
            32'h0000_0102: return 8'h33;
            32'h0000_0103: return 8'h44;
            32'h0000_0104: return 8'h55;
            32'h0000_0302: return 8'h99;
            32'h0000_0303: return 8'h88;
            32'hFFFF_FFFF: return 8'h80;
            32'h0000_0000: return 8'h7F;
            default:       return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bif.ram_wr_o) begin
            wram[bif.ram_a_o[11:0]] <= bif.ram_dout_o;
            wv[bif.ram_a_o[11:0]]   <= 1'b1;
        end
        bif.ram_din_i <= wv[bif.ram_a_o[11:0]] ? wram[bif.ram_a_o[11:0]] : init_val(bif.ram_a_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.if_req_i    = 1'b0;
        bif.if_addr_i   = '0;
        bif.mem_req_i   = 1'b0;
        bif.mem_we_i    = 1'b0;
        bif.mem_len_i   = '0;
        bif.mem_addr_i  = '0;
        bif.mem_wdata_i = '0;
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    // Issue one request in the current (IDLE) cycle T, then follow it
    // cycle by cycle until its done pulse.
    task automatic run_req(input vec_t v, input string name);
        int          n;
        int          lat;
        bit          seq_ok;
        bit          other;
        logic [31:0] got;
        logic [31:0] wd;
        n      = v.is_mem ? ((v.len == 2'd0) ? 1 : (v.len == 2'd1) ? 2 : 4) : 4;
        lat    = 0;
        seq_ok = 1'b1;
        other  = 1'b0;
        got    = '0;
        wd     = v.wdata;
        if (v.is_mem) begin
            bif.mem_req_i   = 1'b1;
            bif.mem_we_i    = v.we;
            bif.mem_len_i   = v.len;
            bif.mem_addr_i  = v.addr;
            bif.mem_wdata_i = v.wdata;
        end else begin
            bif.if_req_i  = 1'b1;
            bif.if_addr_i = v.addr;
        end
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (c <= n) begin
                if (bif.ram_a_o !== v.addr + 32'(c - 1)) seq_ok = 1'b0;
                if (bif.ram_wr_o !== (v.is_mem & v.we)) seq_ok = 1'b0;
                if (bif.busy_o !== 1'b1) seq_ok = 1'b0;
                if (v.is_mem && v.we && bif.ram_dout_o !== wd[8*(c-1) +: 8]) seq_ok = 1'b0;
            end
            if (v.is_mem ? bif.if_done_o : bif.mem_done_o) other = 1'b1;
            if (v.is_mem ? bif.mem_done_o : bif.if_done_o) begin
                lat = c;
                got = v.is_mem ? bif.mem_rdata_o : bif.if_data_o;
            end
        end
        idle_inputs();
        check({name, " latency"}, 32'(lat), 32'(v.exp_lat));
        if (!(v.is_mem && v.we)) check({name, " data"}, got, v.exp_data);
        check({name, " ram seq"}, {31'd0, seq_ok}, 32'd1);
        check({name, " other done"}, {31'd0, other}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int          mem_c;
        int          if_c;
        int          mem_cnt;
        int          if_cnt;
        int          lat;
        bit          ok;
        logic [31:0] got;
        logic [31:0] wd;

        total = 0;
        bad   = 0;

        //             is_mem we len    addr           wdata          exp_data       lat
        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h4433_2211, 6};
        vecs[1] = '{1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         5};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[3] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_7F80, 4};
        vecs[4] = '{1'b1, 1'b0, 2'd0, 32'h0000_0101, 32'h0,         32'h0000_0022, 3};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h0000_0300, 32'h1234_ABCD, 32'h0,         3};
        vecs[6] = '{1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h8899_ABCD, 6};
        vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,         32'h4433_2211, 6};
        vecs[8] = '{1'b0, 1'b0, 2'd2, 32'h0000_0101, 32'h0,         32'h5544_3322, 6};

        rst       = 1'b1;
        bif.rdy_i = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset ram_a", bif.ram_a_o, 32'h0);
        check("reset ctl", {26'd0, bif.ram_wr_o, bif.if_done_o, bif.mem_done_o, bif.busy_o, 2'b00}, 32'h0);
        check("reset data", bif.if_data_o | bif.mem_rdata_o | {24'd0, bif.ram_dout_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous requests: MEM store byte first, then the IF fetch.
        mem_c   = 0;
        if_c    = 0;
        mem_cnt = 0;
        if_cnt  = 0;
        ok      = 1'b0;
        bif.mem_req_i   = 1'b1;
        bif.mem_we_i    = 1'b1;
        bif.mem_len_i   = 2'd0;
        bif.mem_addr_i  = 32'h0000_0400;
        bif.mem_wdata_i = 32'h0000_005A;
        bif.if_req_i    = 1'b1;
        bif.if_addr_i   = 32'h0000_0100;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) ok = (bif.ram_a_o === 32'h400) && (bif.ram_wr_o === 1'b1) && (bif.ram_dout_o === 8'h5A);
            if (bif.mem_done_o === 1'b1) begin
                mem_cnt++;
                mem_c = c;
                bif.mem_req_i = 1'b0;
            end
            if (bif.if_done_o === 1'b1) begin
                if_cnt++;
                if_c = c;
                bif.if_req_i = 1'b0;
            end
        end
        check("prio mem first byte", {31'd0, ok}, 32'd1);
        check("prio mem done cycle", 32'(mem_c), 32'd2);
        check("prio if done cycle", 32'(if_c), 32'd9);
        check("prio mem done count", 32'(mem_cnt), 32'd1);
        check("prio if done count", 32'(if_cnt), 32'd1);
        check("prio if data held", bif.if_data_o, 32'h4433_2211);
        idle_inputs();
        run_req('{1'b1, 1'b0, 2'd0, 32'h0000_0400, 32'h0, 32'h0000_005A, 3}, "prio readback");

        // Reset while the second byte of a word fetch is on the bus.
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h0000_0100;
        @(negedge clk);
        @(negedge clk);
        check("abort 2nd byte addr", bif.ram_a_o, 32'h0000_0101);
        rst = 1'b1;
        #1;
        check("abort ram_a", bif.ram_a_o, 32'h0);
        check("abort ctl", {28'd0, bif.ram_wr_o, bif.if_done_o, bif.mem_done_o, bif.busy_o}, 32'h0);
        check("abort if_data", bif.if_data_o, 32'h0);
        @(negedge clk);
        check("abort no done", {31'd0, bif.if_done_o}, 32'h0);
        rst = 1'b0;
        lat = 0;
        ok  = 1'b0;
        got = '0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) ok = (bif.ram_a_o === 32'h100);
            if (bif.if_done_o === 1'b1) begin
                lat = c;
                got = bif.if_data_o;
            end
        end
        idle_inputs();
        check("restart byte0", {31'd0, ok}, 32'd1);
        check("restart latency", 32'(lat), 32'd6);
        check("restart data", got, 32'h4433_2211);
        @(negedge clk);

        // rdy_i low in IDLE blocks the grant; low mid-write has no effect.
        bif.rdy_i       = 1'b0;
        bif.mem_req_i   = 1'b1;
        bif.mem_we_i    = 1'b1;
        bif.mem_len_i   = 2'd2;
        bif.mem_addr_i  = 32'h0000_0500;
        bif.mem_wdata_i = 32'hCAFE_F00D;
        ok = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bif.ram_a_o !== 32'h0 || bif.ram_wr_o !== 1'b0 || bif.busy_o !== 1'b0 || bif.mem_done_o !== 1'b0)
                ok = 1'b0;
        end
        check("rdy low quiet", {31'd0, ok}, 32'd1);
        bif.rdy_i = 1'b1;
        lat = 0;
        ok  = 1'b1;
        wd  = 32'hCAFE_F00D;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            bif.rdy_i = 1'b0;
            if (c <= 4) begin
                if (bif.ram_wr_o !== 1'b1 || bif.ram_a_o !== 32'h500 + 32'(c - 1) || bif.ram_dout_o !== wd[8*(c-1) +: 8])
                    ok = 1'b0;
            end
            if (bif.mem_done_o === 1'b1) lat = c;
        end
        idle_inputs();
        bif.rdy_i = 1'b1;
        check("rdy mid-write bytes", {31'd0, ok}, 32'd1);
        check("rdy mid-write latency", 32'(lat), 32'd5);
        @(negedge clk);
        run_req('{1'b1, 1'b0, 2'd2, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 6}, "rdy readback");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
